// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side and instruction Wishbone signals of the set-associative cache
interface icache_assoc_if #(
   parameter int RW      = 16,
   parameter int I_WORDS = 2
);
   logic                  mem_req;
   logic                  mem_ppl_submit;
   logic [RW-1:0]         mem_addr;
   logic                  mem_cache_flush;
   logic                  mem_ack;
   logic [RW*I_WORDS-1:0] mem_data;
   logic                  wb_cyc;
   logic                  wb_stb;
   logic                  wb_we;
   logic [1:0]            wb_sel;
   logic [RW-1:0]         wb_adr;
   logic [RW-1:0]         wb_i_dat;
   logic                  wb_ack;
   logic [15:0]           stat_hits;
   logic [15:0]           stat_misses;
   modport slave (
      input  mem_req, mem_ppl_submit, mem_addr, mem_cache_flush, wb_i_dat, wb_ack,
      output mem_ack, mem_data, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, stat_hits, stat_misses
   );
   modport master (
      output mem_req, mem_ppl_submit, mem_addr, mem_cache_flush, wb_i_dat, wb_ack,
      input  mem_ack, mem_data, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, stat_hits, stat_misses
   );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with round-robin victims and hit/miss counters
module icache_assoc #(
   parameter int RW         = 16,
   parameter int I_WORDS    = 2,
   parameter int LINE_INSTR = 4,
   parameter int SETS       = 32,
   parameter int WAYS       = 4
) (
   input logic           i_clk,
   input logic           i_rst,
   icache_assoc_if.slave bus
);
   localparam int OFF_W = $clog2(LINE_INSTR);
   localparam int IDX_W = $clog2(SETS);
   localparam int BURST = LINE_INSTR*I_WORDS;
   localparam int BW    = $clog2(BURST);
   localparam int TAG_W = RW-OFF_W-IDX_W;
   localparam int IW    = RW*I_WORDS;
   localparam int LW    = BURST*RW;
   localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                  state_q;
   logic [BW-1:0]           cnt_q;
   logic                    wb_cyc_q, lk_q, pend_q, drop_q, flush_prev_q, vic_rr_q;
   logic [RW-1:0]           addr_q, pend_addr_q;
   logic [LW-1:0]           line_q;
   logic [WW-1:0]           vic_q;
   logic [SETS-1:0][WAYS-1:0] valid_q;
   logic [SETS-1:0][WW-1:0] rr_q;
   logic [15:0]             hits_q, misses_q;
   logic [TAG_W-1:0]        tag_ram [WAYS][SETS];
   logic [LW-1:0]           line_ram [WAYS][SETS];
   logic [TAG_W-1:0]        tag_rd [WAYS];
   logic [LW-1:0]           line_rd [WAYS];

   logic                    busy, accept, sub_acc, hit, miss_now, final_ack, we, any_inv;
   logic                    pend_d, drop_d;
   logic [RW-1:0]           acc_addr, pend_addr_d;
   logic [IDX_W-1:0]        idx, acc_idx;
   logic [TAG_W-1:0]        tag;
   logic [OFF_W-1:0]        off;
   logic [WW-1:0]           hit_way, inv_way;
   logic [LW-1:0]           fill_line, sel_line;

   assign busy        = state_q == FILL;
   assign acc_addr    = pend_q ? pend_addr_q : bus.mem_addr;
   assign accept      = bus.mem_req & ~busy & ~miss_now & (bus.mem_ppl_submit | pend_q);
   assign sub_acc     = accept & ~pend_q;
   assign pend_d      = (bus.mem_ppl_submit & ~sub_acc) | (pend_q & ~accept);
   assign pend_addr_d = bus.mem_ppl_submit & ~sub_acc ? bus.mem_addr : pend_addr_q;
   assign acc_idx     = acc_addr[OFF_W+IDX_W-1:OFF_W];
   assign idx         = addr_q[OFF_W+IDX_W-1:OFF_W];
   assign tag         = addr_q[RW-1:OFF_W+IDX_W];
   assign off         = addr_q[OFF_W-1:0];
   assign miss_now    = lk_q & ~hit;
   assign final_ack   = busy & bus.wb_ack & (cnt_q == BW'(BURST-1));
   assign drop_d      = final_ack ? 1'b0 : drop_q | (bus.mem_cache_flush & (busy | miss_now));
   assign we          = final_ack & ~drop_q & ~bus.mem_cache_flush & ~i_rst;
   assign sel_line    = final_ack ? fill_line : line_rd[hit_way];

   assign bus.mem_ack     = hit | final_ack;
   assign bus.mem_data    = sel_line[IW*int'(off) +: IW];
   assign bus.wb_cyc      = wb_cyc_q;
   assign bus.wb_stb      = wb_cyc_q;
   assign bus.wb_we       = 1'b0;
   assign bus.wb_sel      = 2'b11;
   assign bus.wb_adr      = {addr_q[RW-1-(BW-OFF_W):OFF_W], cnt_q};
   assign bus.stat_hits   = hits_q;
   assign bus.stat_misses = misses_q;

   // Compare all ways of the looked-up set; also find the lowest-index invalid way as a victim
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (lk_q && !flush_prev_q && valid_q[idx][w] && tag_rd[w] == tag) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
         if (!valid_q[idx][w]) begin
            any_inv = 1'b1;
            inv_way = WW'(w);
         end
      end
   end

   // Assembled line with the word on the bus merged in, so the last word bypasses the buffer
   always_comb begin
      fill_line = line_q;
      fill_line[RW*int'(cnt_q) +: RW] = bus.wb_i_dat;
   end

   // Per-way synchronous-read RAMs: fills write at the fill index, accepts read at the accept index
   always_ff @(posedge i_clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (we && vic_q == WW'(w)) begin
            tag_ram[w][idx]  <= tag;
            line_ram[w][idx] <= fill_line;
         end
         if (accept) begin
            tag_rd[w]  <= tag_ram[w][acc_idx];
            line_rd[w] <= line_ram[w][acc_idx];
         end
      end
   end

   // Fill FSM: latch the victim on a miss, burst the line in, return to idle on the last ack
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         wb_cyc_q <= 1'b0;
         cnt_q    <= '0;
         vic_q    <= '0;
         vic_rr_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         drop_q <= drop_d;
         if (miss_now) begin
            state_q  <= FILL;
            wb_cyc_q <= 1'b1;
            cnt_q    <= '0;
            vic_q    <= any_inv ? inv_way : rr_q[idx];
            vic_rr_q <= ~any_inv;
         end else if (busy && bus.wb_ack) begin
            cnt_q  <= cnt_q + BW'(1);
            line_q <= fill_line;
            if (final_ack) begin
               state_q  <= IDLE;
               wb_cyc_q <= 1'b0;
            end
         end
      end
   end

   // Request tracking, valid bits, round-robin pointers and saturating statistics
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lk_q         <= 1'b0;
         pend_q       <= 1'b0;
         flush_prev_q <= 1'b0;
         valid_q      <= '0;
         rr_q         <= '0;
         hits_q       <= '0;
         misses_q     <= '0;
      end else begin
         lk_q         <= accept;
         pend_q       <= pend_d;
         pend_addr_q  <= pend_addr_d;
         flush_prev_q <= bus.mem_cache_flush;
         if (accept) addr_q <= acc_addr;
         if (bus.mem_cache_flush) valid_q <= '0;
         else if (we) valid_q[idx][vic_q] <= 1'b1;
         if (final_ack && vic_rr_q) rr_q[idx] <= rr_q[idx] == WW'(WAYS-1) ? '0 : rr_q[idx] + WW'(1);
         if (hit && hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
         if (miss_now && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
      end
   end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: scoreboard bench for the set-associative instruction cache
module tb_icache_assoc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] exp_q[$];
   logic [15:0] bus_q[$];
   int          ack_log[$];

   icache_assoc_if #(.RW(16), .I_WORDS(2)) bus ();

   icache_assoc #(.RW(16), .I_WORDS(2), .LINE_INSTR(4), .SETS(32), .WAYS(4)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Zero-wait bus slave whose data word equals its word address
   assign bus.wb_ack   = bus.wb_cyc & bus.wb_stb;
   assign bus.wb_i_dat = bus.wb_adr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops expected instructions on mem_ack and expected burst bases on bus beats
   initial begin
      int          beat;
      logic [15:0] base;
      beat = 0;
      base = '0;
      forever begin
         @(negedge clk);
         if (rst) beat = 0;
         else begin
            if (bus.mem_ack) begin
               ack_log.push_back(cyc);
               chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) chk("mem_data", bus.mem_data, exp_q.pop_front());
            end
            if (bus.wb_cyc && bus.wb_stb && bus.wb_ack) begin
               if (beat == 0) begin
                  chk("burst_expected", 32'(bus_q.size() != 0), 32'd1);
                  if (bus_q.size() != 0) base = bus_q.pop_front();
               end
               chk("wb_adr", 32'(bus.wb_adr), 32'(base + 16'(beat)));
               beat = (beat + 1) % 8;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sub(input logic [15:0] a, input logic [31:0] d, input bit miss, input logic [15:0] b);
      exp_q.push_back(d);
      if (miss) bus_q.push_back(b);
      bus.mem_addr       = a;
      bus.mem_ppl_submit = 1'b1;
      tick();
      bus.mem_ppl_submit = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.wb_cyc); i++) tick();
      chk("drain_acks", 32'(exp_q.size()), 32'd0);
      chk("drain_bursts", 32'(bus_q.size()), 32'd0);
      tick();
      tick();
   endtask

   task automatic wait_cyc();
      for (int i = 0; i < 20 && !bus.wb_cyc; i++) tick();
      chk("cyc_rise", 32'(bus.wb_cyc), 32'd1);
   endtask

   task automatic stats(input int h, input int m);
      chk("stat_hits", 32'(bus.stat_hits), 32'(h));
      chk("stat_misses", 32'(bus.stat_misses), 32'(m));
   endtask

   initial begin
      bus.mem_req         = 1'b0;
      bus.mem_ppl_submit  = 1'b0;
      bus.mem_addr        = '0;
      bus.mem_cache_flush = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_mem_ack", 32'(bus.mem_ack), 32'd0);
      chk("rst_wb_cyc", 32'(bus.wb_cyc), 32'd0);
      chk("rst_wb_stb", 32'(bus.wb_stb), 32'd0);
      chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst_wb_sel", 32'(bus.wb_sel), 32'd3);
      stats(0, 0);
      bus.mem_req = 1'b1;
      tick();

      // cold miss, then three back-to-back hits in the same line
      sub(16'h0040, 32'h0081_0080, 1, 16'h0080);
      drain();
      stats(0, 1);
      sub(16'h0041, 32'h0083_0082, 0, 16'h0000);
      sub(16'h0042, 32'h0085_0084, 0, 16'h0000);
      sub(16'h0043, 32'h0087_0086, 0, 16'h0000);
      drain();
      chk("b2b_span", 32'(ack_log[$] - ack_log[$-2]), 32'd2);
      stats(3, 1);

      // five tags in set 0: fill ways 0..3, then round-robin eviction
      sub(16'h0000, 32'h0001_0000, 1, 16'h0000); drain();
      sub(16'h0080, 32'h0101_0100, 1, 16'h0100); drain();
      sub(16'h0100, 32'h0201_0200, 1, 16'h0200); drain();
      sub(16'h0180, 32'h0301_0300, 1, 16'h0300); drain();
      sub(16'h0200, 32'h0401_0400, 1, 16'h0400); drain();
      sub(16'h0000, 32'h0001_0000, 1, 16'h0000); drain();
      sub(16'h0102, 32'h0205_0204, 0, 16'h0000); drain();
      sub(16'h0080, 32'h0101_0100, 1, 16'h0100); drain();
      sub(16'h0183, 32'h0307_0306, 0, 16'h0000); drain();
      sub(16'h0203, 32'h0407_0406, 0, 16'h0000); drain();
      stats(6, 8);

      // flush during a burst: still acked, but not retained
      sub(16'h0300, 32'h0601_0600, 1, 16'h0600);
      wait_cyc();
      tick();
      tick();
      bus.mem_cache_flush = 1'b1;
      tick();
      bus.mem_cache_flush = 1'b0;
      drain();
      sub(16'h0300, 32'h0601_0600, 1, 16'h0600); drain();
      // flush then immediate resubmit of a cached line
      bus.mem_cache_flush = 1'b1;
      tick();
      bus.mem_cache_flush = 1'b0;
      sub(16'h0300, 32'h0601_0600, 1, 16'h0600); drain();
      // flush in the hit cycle: ack uses pre-flush contents, next lookup misses
      exp_q.push_back(32'h0603_0602);
      bus.mem_addr       = 16'h0301;
      bus.mem_ppl_submit = 1'b1;
      tick();
      bus.mem_ppl_submit  = 1'b0;
      bus.mem_cache_flush = 1'b1;
      tick();
      bus.mem_cache_flush = 1'b0;
      drain();
      sub(16'h0301, 32'h0603_0602, 1, 16'h0600); drain();
      stats(7, 12);

      // submit during a fill is held and accepted right after the final ack
      sub(16'h0400, 32'h0801_0800, 1, 16'h0800);
      wait_cyc();
      tick();
      sub(16'h0401, 32'h0803_0802, 0, 16'h0000);
      drain();
      chk("pending_gap", 32'(ack_log[$] - ack_log[$-1]), 32'd2);
      stats(8, 13);

      // reset in the middle of a burst
      bus_q.push_back(16'h0A00);
      bus.mem_addr       = 16'h0500;
      bus.mem_ppl_submit = 1'b1;
      tick();
      bus.mem_ppl_submit = 1'b0;
      wait_cyc();
      repeat (3) tick();
      rst = 1'b1;
      exp_q.delete();
      bus_q.delete();
      tick();
      rst = 1'b0;
      chk("rst_mid_cyc", 32'(bus.wb_cyc), 32'd0);
      stats(0, 0);
      tick();
      sub(16'h0203, 32'h0407_0406, 1, 16'h0400); drain();
      sub(16'h0041, 32'h0083_0082, 1, 16'h0080); drain();
      sub(16'h0401, 32'h0803_0802, 1, 16'h0800); drain();
      stats(0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
